uart_packet_controller: RTL and testbench

Second-generation PC link for the sensor core. It contains its own 8N1 UART serialiser and deserialiser, so no external Avalon UART IP is needed. TX frames a variable-length sensor packet of up to MAX_BYTES bytes and sends it MSB byte first. RX decodes one- and two-byte PC commands into a 16-bit command word, and only STOP is honoured while the core is busy.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_phy.sv | 174 +++++++++++++++++
 rtl/uart_packet_controller.sv | 159 +++++++++++++++
 tb/tb_uart_packet_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and command payload for the UART packet link.
package uart_pkg;

  // PC command opcodes
  localparam logic [7:0] UART_SG_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] UART_SG_STOP = 8'h53;  // 'S'

  // Packet tags carried in payload byte 0 (not interpreted by the link)
  localparam logic [7:0] TAG_ADS1292 = 8'h41;   // 'A'
  localparam logic [7:0] TAG_MPR121  = 8'h4D;   // 'M'

  // Bit-level serialiser states
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_BITS,
    TX_STOP
  } tx_state_e;

  // Bit-level deserialiser states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

  // Packet sequencer states
  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } seq_state_e;

  // Command decoder states
  typedef enum logic {
    CMD_OPCODE,
    CMD_ARG
  } cmd_state_e;

  // Decoded command word
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] arg;
  } cmd_word_t;

endpackage

// File: rtl/uart_phy.sv
// 8N1 bit-level serialiser and deserialiser, each timed by its own bit counter.
module uart_phy
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  // byte transmit interface; a byte is taken when tx_valid_i && tx_ready_c_o
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_c_o,
  output logic       txd_o,
  // serial receive and decoded byte
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_c_o,
  output logic       rx_err_c_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e       tx_state_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_sh_q;
  logic            txd_q;
  logic            tx_end_c;
  logic            tx_ready_c;

  rx_state_e       rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            rx_prev_q;
  logic            rx_mid_c;
  logic            rx_end_c;

  assign tx_end_c   = (tx_cnt_q == CW'(CLKS_PER_BIT - 1));
  // Accepting on the last stop-bit cycle chains bytes with no idle gap
  assign tx_ready_c = (tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_end_c);

  // Transmit serialiser: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else if (tx_ready_c && tx_valid_i) begin
      tx_state_q <= TX_START;
      tx_cnt_q   <= '0;
      tx_sh_q    <= tx_data_i;
      txd_q      <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
        end
        TX_START: begin
          if (tx_end_c) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_sh_q[0];
            tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
            tx_state_q <= TX_BITS;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_BITS: begin
          if (tx_end_c) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_end_c) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign rx_mid_c = (rx_cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
  assign rx_end_c = (rx_cnt_q == CW'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receive deserialiser: start-bit glitch recheck, then mid-bit sampling
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_mid_c) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_BITS;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_BITS: begin
          if (rx_end_c) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_end_c) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign tx_ready_c_o = tx_ready_c;
  assign txd_o        = txd_q;
  assign rx_data_o    = rx_sh_q;
  assign rx_valid_c_o = (rx_state_q == RX_STOP) && rx_end_c && rx_sync_q;
  assign rx_err_c_o   = (rx_state_q == RX_STOP) && rx_end_c && !rx_sync_q;

endmodule

// File: rtl/uart_packet_controller.sv
// Sensor packet transmitter and PC command decoder on top of the 8N1 PHY.
module uart_packet_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MAX_BYTES    = 6,
  parameter int unsigned ARG_TIMEOUT  = 65535
) (
  input  logic                           i_CLK,
  input  logic                           i_RSTN,
  input  logic [8*MAX_BYTES-1:0]         i_UART_DATA_TX,
  input  logic [$clog2(MAX_BYTES+1)-1:0] i_UART_DATA_TX_LEN,
  input  logic                           i_UART_DATA_TX_VALID,
  output logic                           o_DATA_TX_READY,
  output logic [15:0]                    o_UART_DATA_RX,
  output logic                           o_UART_DATA_RX_VALID,
  output logic                           o_UART_RX_ERR,
  input  logic                           i_CORE_BUSY,
  input  logic                           i_UART_RXD,
  output logic                           o_UART_TXD
);

  localparam int unsigned PW = 8 * MAX_BYTES;
  localparam int unsigned LW = $clog2(MAX_BYTES + 1);
  localparam int unsigned TW = $clog2(ARG_TIMEOUT + 1);

  logic          phy_tx_valid_c;
  logic [7:0]    phy_tx_data_c;
  logic          phy_tx_ready_c;
  logic [7:0]    phy_rx_data;
  logic          phy_rx_valid_c;
  logic          phy_rx_err_c;

  seq_state_e    seq_q;
  logic [PW-1:0] pkt_sh_q;
  logic [LW-1:0] pkt_rem_q;
  logic          tx_ready_q;
  logic [LW-1:0] len_clamp_c;
  logic          hs_c;

  cmd_state_e    cmd_q;
  logic [7:0]    cmd_op_q;
  logic [TW-1:0] cmd_cnt_q;
  cmd_word_t     rx_word_q;
  logic          rx_valid_q;
  logic          rx_err_q;

  uart_phy #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_phy (
    .clk_i        (i_CLK),
    .rst_ni       (i_RSTN),
    .tx_valid_i   (phy_tx_valid_c),
    .tx_data_i    (phy_tx_data_c),
    .tx_ready_c_o (phy_tx_ready_c),
    .txd_o        (o_UART_TXD),
    .rxd_i        (i_UART_RXD),
    .rx_data_o    (phy_rx_data),
    .rx_valid_c_o (phy_rx_valid_c),
    .rx_err_c_o   (phy_rx_err_c)
  );

  // Handshake qualification and the byte offered to the PHY; the first byte
  // goes straight from the input so its start bit begins right after the handshake
  always_comb begin
    len_clamp_c    = (i_UART_DATA_TX_LEN > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : i_UART_DATA_TX_LEN;
    hs_c           = (seq_q == SEQ_IDLE) && i_UART_DATA_TX_VALID && (len_clamp_c != '0);
    phy_tx_valid_c = hs_c || ((seq_q == SEQ_SEND) && (pkt_rem_q != '0));
    phy_tx_data_c  = hs_c ? i_UART_DATA_TX[PW-1 -: 8] : pkt_sh_q[PW-1 -: 8];
  end

  // Packet sequencer: latch payload, feed bytes MSB-byte first, shift and count down
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      seq_q      <= SEQ_IDLE;
      pkt_sh_q   <= '0;
      pkt_rem_q  <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      case (seq_q)
        SEQ_IDLE: begin
          if (hs_c) begin
            pkt_sh_q   <= i_UART_DATA_TX << 8;
            pkt_rem_q  <= len_clamp_c - LW'(1);
            tx_ready_q <= 1'b0;
            seq_q      <= SEQ_SEND;
          end
        end
        SEQ_SEND: begin
          if (phy_tx_ready_c) begin
            if (pkt_rem_q != '0) begin
              pkt_sh_q  <= pkt_sh_q << 8;
              pkt_rem_q <= pkt_rem_q - LW'(1);
            end else begin
              tx_ready_q <= 1'b1;
              seq_q      <= SEQ_IDLE;
            end
          end
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  // Command decoder: opcode/argument assembly, busy filtering, argument timeout
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      cmd_q      <= CMD_OPCODE;
      cmd_op_q   <= '0;
      cmd_cnt_q  <= '0;
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= phy_rx_err_c;
      case (cmd_q)
        CMD_OPCODE: begin
          if (phy_rx_valid_c && (phy_rx_data != 8'h00)) begin
            if (i_CORE_BUSY) begin
              if (phy_rx_data == UART_SG_STOP) begin
                rx_word_q  <= '{opcode: UART_SG_STOP, arg: 8'h00};
                rx_valid_q <= 1'b1;
              end
            end else if ((phy_rx_data == UART_SG_RUN) || (phy_rx_data == UART_SG_STOP)) begin
              rx_word_q  <= '{opcode: phy_rx_data, arg: 8'h00};
              rx_valid_q <= 1'b1;
            end else begin
              cmd_op_q  <= phy_rx_data;
              cmd_cnt_q <= '0;
              cmd_q     <= CMD_ARG;
            end
          end
        end
        CMD_ARG: begin
          if (i_CORE_BUSY) begin
            cmd_q <= CMD_OPCODE;
          end else if (phy_rx_valid_c) begin
            rx_word_q  <= '{opcode: cmd_op_q, arg: phy_rx_data};
            rx_valid_q <= 1'b1;
            cmd_q      <= CMD_OPCODE;
          end else if (cmd_cnt_q == TW'(ARG_TIMEOUT - 1)) begin
            rx_err_q <= 1'b1;
            cmd_q    <= CMD_OPCODE;
          end else begin
            cmd_cnt_q <= cmd_cnt_q + TW'(1);
          end
        end
        default: cmd_q <= CMD_OPCODE;
      endcase
    end
  end

  assign o_DATA_TX_READY      = tx_ready_q;
  assign o_UART_DATA_RX       = rx_word_q;
  assign o_UART_DATA_RX_VALID = rx_valid_q;
  assign o_UART_RX_ERR        = rx_err_q;

endmodule

// File: tb/tb_uart_packet_controller.sv
// Directed bench for uart_packet_controller with a cycle-level TX waveform
// model and an event-level command decoder model.
module tb_uart_packet_controller;
  import uart_pkg::*;

  localparam int unsigned CPB = 4;
  localparam int unsigned MB  = 6;
  localparam int unsigned AT  = 100;
  localparam int unsigned PW  = 8 * MB;
  localparam int unsigned LW  = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] tx_data;
  logic [LW-1:0] tx_len;
  logic          tx_valid;
  logic          tx_ready;
  logic [15:0]   rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          busy;
  logic          rxd;
  logic          txd;

  always #5 clk = ~clk;

  uart_packet_controller #(
    .CLKS_PER_BIT (CPB),
    .MAX_BYTES    (MB),
    .ARG_TIMEOUT  (AT)
  ) dut (
    .i_CLK                (clk),
    .i_RSTN               (rst_n),
    .i_UART_DATA_TX       (tx_data),
    .i_UART_DATA_TX_LEN   (tx_len),
    .i_UART_DATA_TX_VALID (tx_valid),
    .o_DATA_TX_READY      (tx_ready),
    .o_UART_DATA_RX       (rx_data),
    .o_UART_DATA_RX_VALID (rx_valid),
    .o_UART_RX_ERR        (rx_err),
    .i_CORE_BUSY          (busy),
    .i_UART_RXD           (rxd),
    .o_UART_TXD           (txd)
  );

  typedef struct {
    bit          is_err;
    logic [15:0] val;
  } rx_ev_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          low_cnt = 0;
  int          err_pulses = 0;
  bit          exp_tx[$];
  rx_ev_t      exp_rx[$];
  logic [15:0] exp_last = 16'h0000;
  bit          m_in_arg = 1'b0;
  logic [7:0]  m_op = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampl(input int l);
    return (l > int'(MB)) ? int'(MB) : l;
  endfunction

  // Expected TXD is the queue head; the queue holds one entry per cycle of the packet
  task automatic model_update();
    bit         hs;
    int         n;
    logic [7:0] b;
    if (!rst_n) begin
      exp_tx.delete();
    end else begin
      n  = clampl(int'(tx_len));
      hs = (exp_tx.size() == 0) && tx_valid && (n > 0);
      if (exp_tx.size() > 0) void'(exp_tx.pop_front());
      if (hs) begin
        for (int k = 0; k < n; k++) begin
          b = tx_data[PW-1-8*k -: 8];
          repeat (CPB) exp_tx.push_back(1'b0);
          for (int i = 0; i < 8; i++) repeat (CPB) exp_tx.push_back(b[i]);
          repeat (CPB) exp_tx.push_back(1'b1);
        end
      end
    end
  endtask

  task automatic compare();
    bit     active;
    rx_ev_t ev;
    active = rst_n && (exp_tx.size() > 0);
    chk("txd", 32'(txd), active ? 32'(exp_tx[0]) : 32'd1);
    chk("tx_ready", 32'(tx_ready), active ? 32'd0 : 32'd1);
    if (!tx_ready) low_cnt++;
    chk("rx_valid_err_overlap", 32'(rx_valid & rx_err), 32'd0);
    if (rx_err) err_pulses++;
    if (rx_valid || rx_err) begin
      if (exp_rx.size() == 0) begin
        chk("rx_unexpected_event", 32'({rx_err, rx_valid}), 32'd0);
      end else begin
        ev = exp_rx.pop_front();
        chk("rx_event_kind_err", 32'(rx_err), 32'(ev.is_err));
        if (!ev.is_err) exp_last = ev.val;
      end
    end
    chk("rx_data", 32'(rx_data), 32'(exp_last));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  // Command decoding rules applied to one received frame
  task automatic rx_model(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_rx.push_back('{is_err: 1'b1, val: 16'h0000});
    end else if (m_in_arg) begin
      exp_rx.push_back('{is_err: 1'b0, val: {m_op, b}});
      m_in_arg = 1'b0;
    end else if (b == 8'h00) begin
      m_in_arg = 1'b0;
    end else if (busy) begin
      if (b == UART_SG_STOP) exp_rx.push_back('{is_err: 1'b0, val: {UART_SG_STOP, 8'h00}});
    end else if ((b == UART_SG_RUN) || (b == UART_SG_STOP)) begin
      exp_rx.push_back('{is_err: 1'b0, val: {b, 8'h00}});
    end else begin
      m_op     = b;
      m_in_arg = 1'b1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit ok);
    rx_model(b, ok);
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = ok;
    repeat (CPB) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  task automatic start_tx(input logic [PW-1:0] d, input logic [LW-1:0] l);
    tx_data  = d;
    tx_len   = l;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    int l0;
    int e0;
    rst_n    = 1'b0;
    tx_data  = '0;
    tx_len   = '0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    rxd      = 1'b1;
    repeat (3) tick();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_err", 32'(rx_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    // 1: full six-byte packet
    l0 = low_cnt;
    start_tx({TAG_ADS1292, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}, LW'(6));
    chk("t1_model_cycles", 32'(exp_tx.size()), 32'd240);
    for (int c = 0; c < 240; c++) begin
      case (c)
        6:   chk("t1_A_bit0", 32'(txd), 32'd1);
        10:  chk("t1_A_bit1", 32'(txd), 32'd0);
        30:  chk("t1_A_bit6", 32'(txd), 32'd1);
        42:  chk("t1_b1_start", 32'(txd), 32'd0);
        46:  chk("t1_12_bit0", 32'(txd), 32'd0);
        50:  chk("t1_12_bit1", 32'(txd), 32'd1);
        238: chk("t1_last_stop", 32'(txd), 32'd1);
        default: ;
      endcase
      tick();
    end
    chk("t1_ready_low_cycles", 32'(low_cnt - l0), 32'd240);
    chk("t1_ready_back", 32'(tx_ready), 32'd1);

    // 2: length 3, 0 and 7 (clamped to 6)
    l0 = low_cnt;
    start_tx({8'hC5, 8'h0F, 8'hF0, 8'h11, 8'h22, 8'h33}, LW'(3));
    repeat (129) tick();
    chk("t2_len3_low_cycles", 32'(low_cnt - l0), 32'd120);
    l0 = low_cnt;
    tx_len   = '0;
    tx_valid = 1'b1;
    repeat (2) tick();
    tx_valid = 1'b0;
    repeat (20) tick();
    chk("t2_len0_low_cycles", 32'(low_cnt - l0), 32'd0);
    l0 = low_cnt;
    start_tx({TAG_MPR121, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h81}, LW'(7));
    chk("t2_len7_model_cycles", 32'(exp_tx.size()), 32'd240);
    repeat (249) tick();
    chk("t2_len7_low_cycles", 32'(low_cnt - l0), 32'd240);

    // 3: RUN, then read command with argument
    send_rx(UART_SG_RUN, 1'b1);
    chk("t3_run_word", 32'(rx_data), 32'h5200);
    send_rx(8'h10, 1'b1);
    send_rx(8'h2C, 1'b1);
    repeat (10) tick();
    chk("t3_pending", 32'(exp_rx.size()), 32'd0);
    chk("t3_read_word", 32'(rx_data), 32'h102C);

    // 4: busy filters everything but STOP
    busy = 1'b1;
    send_rx(UART_SG_RUN, 1'b1);
    chk("t4_run_ignored", 32'(rx_data), 32'h102C);
    send_rx(UART_SG_STOP, 1'b1);
    repeat (4) tick();
    busy = 1'b0;
    chk("t4_stop_word", 32'(rx_data), 32'h5300);
    chk("t4_pending", 32'(exp_rx.size()), 32'd0);

    // 5: framing error, then argument timeout, then recovery
    e0 = err_pulses;
    send_rx(8'h10, 1'b0);
    repeat (4) tick();
    chk("t5_frame_err_pulses", 32'(err_pulses - e0), 32'd1);
    chk("t5_frame_err_no_word", 32'(rx_data), 32'h5300);
    send_rx(8'h10, 1'b1);
    exp_rx.push_back('{is_err: 1'b1, val: 16'h0000});
    m_in_arg = 1'b0;
    e0 = err_pulses;
    repeat (80) tick();
    chk("t5_no_early_timeout", 32'(err_pulses - e0), 32'd0);
    repeat (30) tick();
    chk("t5_timeout_err", 32'(err_pulses - e0), 32'd1);
    send_rx(UART_SG_RUN, 1'b1);
    repeat (4) tick();
    chk("t5_run_after_timeout", 32'(rx_data), 32'h5200);
    chk("t5_pending", 32'(exp_rx.size()), 32'd0);

    // 6: reset in the middle of a byte, then a clean packet
    start_tx({TAG_ADS1292, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33}, LW'(6));
    repeat (15) tick();
    rst_n    = 1'b0;
    exp_last = 16'h0000;
    m_in_arg = 1'b0;
    #1;
    chk("t6_rst_txd", 32'(txd), 32'd1);
    chk("t6_rst_ready", 32'(tx_ready), 32'd1);
    chk("t6_rst_rx_data", 32'(rx_data), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    l0 = low_cnt;
    start_tx({TAG_MPR121, 8'hC3, 32'h0}, LW'(2));
    repeat (85) tick();
    chk("t6_post_rst_low_cycles", 32'(low_cnt - l0), 32'd80);
    chk("t6_post_rst_ready", 32'(tx_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
